// File: rtl/seq_divider_4b_pkg.sv
// Shared constants and state encoding for the sequential divider.
// Imported by the divider top and its trial-subtract unit.
package seq_divider_4b_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int COUNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    DBZ  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_4b_div_trial_sub.sv
// Trial subtract A - D as A + ~D + 1 on a ripple full-adder chain.
// Four data slices plus one extra slice for the partial remainder MSB.
module div_trial_sub
  import seq_divider_4b_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   diff,
  output logic             no_borrow
);

  logic [WIDTH:0]   b;
  logic [WIDTH+1:0] c;

  assign b    = ~{1'b0, d};
  assign c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign diff[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  // carry out of the top slice means A >= D
  assign no_borrow = c[WIDTH+1];

endmodule

// File: rtl/seq_divider_4b.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
// One trial subtract per clock; results held until the next accept.
module seq_divider_4b
  import seq_divider_4b_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t state, state_nx;

  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [COUNT_W-1:0] count;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   a_nx;
  logic [WIDTH-1:0] q_nx;
  logic             accept;
  logic             last;

  assign a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_sub (
    .a        (a_sh),
    .d        (d_q),
    .diff     (diff),
    .no_borrow(no_borrow)
  );

  assign a_nx   = no_borrow ? diff : a_sh;
  assign q_nx   = {q_q[WIDTH-2:0], no_borrow};
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (count == COUNT_W'(WIDTH - 1));

  assign busy = (state == RUN) || (state == DBZ);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: zero divisor skips the iterations entirely
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nx = IDLE;
        if (start) state_nx = (divisor == '0) ? DBZ : RUN;
      end
      RUN:     if (last) state_nx = DONE;
      DBZ:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // shift registers, counter and held result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      a_q         <= '0;
      q_q         <= dividend;
      d_q         <= divisor;
      count       <= '0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      a_q   <= a_nx;
      q_q   <= q_nx;
      count <= count + COUNT_W'(1);
      if (last) begin
        quotient  <= q_nx;
        remainder <= a_nx[WIDTH-1:0];
      end
    end else if (state == DBZ) begin
      quotient    <= '1;
      remainder   <= q_q;
      div_by_zero <= 1'b1;
    end
  end

endmodule
